// File: rtl/reg_dst_pkg.sv
// Shared select encodings and the hardwired-zero register index for the destination pipe.
package reg_dst_pkg;

    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_C   = 2'b10;
    localparam logic [1:0] SEL_ILL = 2'b11;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_dst_stage.sv
// One destination-pipe register (valid, we, addr): async clear, hold on stall, kill on flush.
// Flush clears valid/we but keeps addr, since addr is meaningless once the entry is dead.
module reg_dst_stage #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr
);

    logic              r_valid;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
        end else if (!i_stall) begin
            r_valid <= i_valid;
            r_we    <= i_we;
            r_addr  <= i_addr;
        end
    end

    assign o_valid = r_valid;
    assign o_we    = r_we;
    assign o_addr  = r_addr;

endmodule

// File: rtl/reg_dst_pipe.sv
// Selects the write-destination register, carries it through STAGES registers to writeback and flags RAW hazards.
// Optional REG_DST_PIPE_HAZ_IDX_EN adds haz_idx_a/haz_idx_b (youngest matching stage) for forwarding control.
module reg_dst_pipe
    import reg_dst_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    input  logic [ADDR_W-1:0] c,
    input  logic [1:0]        sel,
    input  logic              reg_write,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    output logic [ADDR_W-1:0] out,
    output logic              out_valid,
    output logic              out_we,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              sel_err
`ifdef REG_DST_PIPE_HAZ_IDX_EN
    ,
    output logic [$clog2(STAGES)-1:0] haz_idx_a,
    output logic [$clog2(STAGES)-1:0] haz_idx_b
`endif
);

    logic                           w_new_valid;
    logic                           w_new_we;
    logic [ADDR_W-1:0]              w_new_addr;
    logic [STAGES-1:0]              w_valid;
    logic [STAGES-1:0]              w_we;
    logic [STAGES-1:0][ADDR_W-1:0]  w_addr;
    logic [STAGES-1:0]              w_d_valid;
    logic [STAGES-1:0]              w_d_we;
    logic [STAGES-1:0][ADDR_W-1:0]  w_d_addr;
    logic                           r_sel_err;

    // An illegal select turns the entry into a bubble with a zero address.
    always_comb begin
        w_new_addr = '0;
        case (sel)
            SEL_A:   w_new_addr = a;
            SEL_B:   w_new_addr = b;
            SEL_C:   w_new_addr = c;
            default: w_new_addr = '0;
        endcase
    end

    assign w_new_valid = in_valid && (sel != SEL_ILL);
    assign w_new_we    = w_new_valid && reg_write && (w_new_addr != ADDR_W'(ZERO_REG));

    assign w_d_valid = {w_valid[STAGES-2:0], w_new_valid};
    assign w_d_we    = {w_we[STAGES-2:0], w_new_we};
    assign w_d_addr  = {w_addr[STAGES-2:0], w_new_addr};

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        reg_dst_stage #(.ADDR_W(ADDR_W)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_stall (stall),
            .i_flush (flush),
            .i_valid (w_d_valid[g]),
            .i_we    (w_d_we[g]),
            .i_addr  (w_d_addr[g]),
            .o_valid (w_valid[g]),
            .o_we    (w_we[g]),
            .o_addr  (w_addr[g])
        );
    end

    // The error pulse only reports entries the pipe actually consumed this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= in_valid && (sel == SEL_ILL) && !stall && !flush;
        end
    end

    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (w_we[i] && (w_addr[i] == src_a)) hazard_a = 1'b1;
            if (w_we[i] && (w_addr[i] == src_b)) hazard_b = 1'b1;
        end
        if (src_a == ADDR_W'(ZERO_REG)) hazard_a = 1'b0;
        if (src_b == ADDR_W'(ZERO_REG)) hazard_b = 1'b0;
    end

`ifdef REG_DST_PIPE_HAZ_IDX_EN
    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        haz_idx_a = '0;
        haz_idx_b = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (w_we[i] && (w_addr[i] == src_a) && (src_a != ADDR_W'(ZERO_REG)))
                haz_idx_a = $clog2(STAGES)'(i);
            if (w_we[i] && (w_addr[i] == src_b) && (src_b != ADDR_W'(ZERO_REG)))
                haz_idx_b = $clog2(STAGES)'(i);
        end
    end
`endif

    assign out       = w_addr[STAGES-1];
    assign out_valid = w_valid[STAGES-1];
    assign out_we    = w_we[STAGES-1];
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_reg_dst_pipe.sv
// Directed and randomized bench for reg_dst_pipe against a queue-based reference model.
module tb_reg_dst_pipe;

    localparam int ADDR_W = 4;
    localparam int STAGES = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, reg_write, stall, flush;
    logic [ADDR_W-1:0] a, b, c, src_a, src_b;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] out;
    logic              out_valid, out_we, hazard_a, hazard_b, sel_err;
`ifdef REG_DST_PIPE_HAZ_IDX_EN
    logic [$clog2(STAGES)-1:0] haz_idx_a, haz_idx_b;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              v;
        logic              we;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    ent_t m_pipe[$];
    logic m_sel_err;

    always #5 clk = ~clk;

    reg_dst_pipe #(.ADDR_W(ADDR_W), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
        .sel(sel), .reg_write(reg_write), .stall(stall), .flush(flush),
        .src_a(src_a), .src_b(src_b), .out(out), .out_valid(out_valid),
        .out_we(out_we), .hazard_a(hazard_a), .hazard_b(hazard_b), .sel_err(sel_err)
`ifdef REG_DST_PIPE_HAZ_IDX_EN
        , .haz_idx_a(haz_idx_a), .haz_idx_b(haz_idx_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        e.v = 1'b0; e.we = 1'b0; e.addr = '0;
        m_pipe.delete();
        for (int i = 0; i < STAGES; i++) m_pipe.push_back(e);
        m_sel_err = 1'b0;
    endtask

    // Returns 1 and the youngest index of an in-flight register write to src.
    task automatic model_haz(input logic [ADDR_W-1:0] src, output logic hit, output int idx);
        hit = 1'b0;
        idx = 0;
        if (src != 0) begin
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (m_pipe[i].we && m_pipe[i].addr == src) begin
                    hit = 1'b1;
                    idx = i;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic ha, hb;
        int   ia, ib;
        model_haz(src_a, ha, ia);
        model_haz(src_b, hb, ib);
        chk({tag, ".out"},       32'(out),       32'(m_pipe[STAGES-1].addr));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_pipe[STAGES-1].v));
        chk({tag, ".out_we"},    32'(out_we),    32'(m_pipe[STAGES-1].we));
        chk({tag, ".hazard_a"},  32'(hazard_a),  32'(ha));
        chk({tag, ".hazard_b"},  32'(hazard_b),  32'(hb));
        chk({tag, ".sel_err"},   32'(sel_err),   32'(m_sel_err));
`ifdef REG_DST_PIPE_HAZ_IDX_EN
        chk({tag, ".haz_idx_a"}, 32'(haz_idx_a), 32'(ia));
        chk({tag, ".haz_idx_b"}, 32'(haz_idx_b), 32'(ib));
`endif
    endtask

    // Apply one clock edge with the currently driven inputs, then update the model and check.
    task automatic tick(input string tag);
        ent_t e;
        e.v    = in_valid && sel != 2'b11;
        e.addr = (sel == 2'b00) ? a : (sel == 2'b01) ? b : (sel == 2'b10) ? c : '0;
        e.we   = e.v && reg_write && e.addr != 0;
        @(posedge clk);
        #1;
        m_sel_err = in_valid && sel == 2'b11 && !stall && !flush;
        if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                m_pipe[i].v  = 1'b0;
                m_pipe[i].we = 1'b0;
            end
        end else if (!stall) begin
            m_pipe.push_front(e);
            void'(m_pipe.pop_back());
        end
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic rw);
        in_valid = v; sel = s; reg_write = rw;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; reg_write = 1'b0; stall = 1'b0; flush = 1'b0;
        a = '0; b = '0; c = '0; sel = 2'b00; src_a = '0; src_b = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Select and latency: entries presented on three consecutive edges.
        a = 4'b0011; b = 4'b0101; c = 4'b1111;
        drive(1'b1, 2'b00, 1'b1); tick("sel_a");
        drive(1'b1, 2'b01, 1'b1); tick("sel_b");
        drive(1'b1, 2'b10, 1'b1); tick("sel_c");
        chk("latency_first", 32'({out_valid, out_we, out}), 32'({2'b11, 4'b0011}));
        drive(1'b0, 2'b00, 1'b0); tick("drain1");
        chk("latency_second", 32'(out), 32'(4'b0101));
        tick("drain2");
        chk("latency_third", 32'(out), 32'(4'b1111));

        // Illegal select produces a bubble and a one-cycle error pulse.
        drive(1'b1, 2'b11, 1'b1); tick("ill");
        chk("sel_err_pulse", 32'(sel_err), 32'd1);
        drive(1'b0, 2'b00, 1'b0); tick("ill_after");
        chk("sel_err_clear", 32'(sel_err), 32'd0);
        tick("ill_drain");
        chk("bubble_out_valid", 32'(out_valid), 32'd0);

        // Zero destination: valid but never written.
        a = 4'b0000;
        drive(1'b1, 2'b00, 1'b1); tick("zero0");
        src_a = 4'b0000;
        drive(1'b0, 2'b00, 1'b0); tick("zero1");
        tick("zero2");
        chk("zero_we", 32'({out_valid, out_we}), 32'({1'b1, 1'b0}));
        chk("zero_src_no_haz", 32'(hazard_a), 32'd0);

        // Hazard against an in-flight write to 0101, including stage index priority.
        a = 4'b0101; b = 4'b0110; c = 4'b1000;
        drive(1'b1, 2'b00, 1'b1); tick("haz0");
        drive(1'b1, 2'b10, 1'b1); tick("haz1");
        src_a = 4'b0101; src_b = 4'b0110;
        drive(1'b1, 2'b00, 1'b1); tick("haz2");
        chk("hazard_a_hit", 32'(hazard_a), 32'd1);
        chk("hazard_b_miss", 32'(hazard_b), 32'd0);
`ifdef REG_DST_PIPE_HAZ_IDX_EN
        chk("haz_idx_youngest", 32'(haz_idx_a), 32'd0);
`endif

        // Stall with three valid entries holds the pipe and drops inputs.
        stall = 1'b1;
        a = 4'b1010;
        drive(1'b1, 2'b00, 1'b1); tick("stall0");
        chk("stall_hold_out", 32'(out), 32'(4'b0101));
        tick("stall1");
        chk("stall_hold_out2", 32'(out), 32'(4'b0101));
        drive(1'b1, 2'b11, 1'b1); tick("stall_ill");
        chk("stall_no_sel_err", 32'(sel_err), 32'd0);

        // Flush wins over stall and empties the pipe.
        flush = 1'b1;
        drive(1'b1, 2'b00, 1'b1); tick("flush");
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 2'b00, 1'b0);
        for (int i = 0; i < STAGES; i++) begin
            chk("flush_out_valid", 32'(out_valid), 32'd0);
            tick("post_flush");
        end

        // Randomized traffic with occasional stalls and flushes.
        for (int n = 0; n < 400; n++) begin
            a = ADDR_W'($urandom_range(0, 7));
            b = ADDR_W'($urandom_range(0, 7));
            c = ADDR_W'($urandom_range(0, 7));
            src_a = ADDR_W'($urandom_range(0, 7));
            src_b = ADDR_W'($urandom_range(0, 7));
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            drive(1'($urandom), 2'($urandom), 1'($urandom));
            if (flush && sel == 2'b11) sel = 2'b00;
            tick("rand");
        end

        // Asynchronous reset mid-run with a full pipe clears outputs before any edge.
        stall = 1'b0; flush = 1'b0;
        a = 4'b0111; src_a = 4'b0111; src_b = 4'b0111;
        drive(1'b1, 2'b00, 1'b1);
        for (int i = 0; i < STAGES; i++) tick("refill");
        chk("refill_valid", 32'({out_valid, hazard_a}), 32'({1'b1, 1'b1}));
        drive(1'b1, 2'b11, 1'b1); tick("refill_ill");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 1'b0);
        tick("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_dst_pipe.md
Name: reg_dst_pipe

Overview:
- Parametrised successor to the 3-to-1 register-destination mux. Selects the write-destination register address from three candidates and carries it, with valid and write-enable, through STAGES pipeline registers to the writeback port.
- Sits between decode and the register file.
- Also flags read-after-write hazards for two source addresses against every in-flight destination.

Parameters:
- ADDR_W, 4, register address width in bits.
- STAGES, 3, number of pipeline registers (legal 2..8).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a decode entry is presented this cycle.
- a  in  ADDR_W  candidate 0 (rt field).
- b  in  ADDR_W  candidate 1 (rd field).
- c  in  ADDR_W  candidate 2 (link register).
- sel  in  2  destination select.
- reg_write  in  1  the entry writes the register file.
- stall  in  1  hold the whole pipe.
- flush  in  1  kill all in-flight entries.
- src_a  in  ADDR_W  source address A for the hazard check.
- src_b  in  ADDR_W  source address B for the hazard check.
- out  out  ADDR_W  writeback destination address (stage STAGES-1).
- out_valid  out  1  writeback entry is valid.
- out_we  out  1  writeback write enable.
- hazard_a  out  1  src_a matches an in-flight write.
- hazard_b  out  1  src_b matches an in-flight write.
- sel_err  out  1  illegal sel seen (one-cycle pulse).

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset: every stage has valid=0, we=0, addr=0. Outputs are out=0, out_valid=0, out_we=0, hazard_a=0, hazard_b=0, sel_err=0.
- Select: sel=00 picks a, 01 picks b, 10 picks c, 11 is illegal.
- Illegal sel (in_valid=1, sel=11):
  - the entry enters as a bubble (valid=0, we=0, addr=0);
  - sel_err is registered high for exactly one cycle.
- Entry formation: valid=in_valid; addr=selected candidate; we=in_valid & reg_write & (addr != 0). Register 0 is hardwired and never written.
- Advance (stall=0, flush=0): stage[0] loads the new entry; stage[i] loads stage[i-1].
- Latency: an entry accepted at edge N appears on out/out_valid/out_we after edge N+STAGES-1, i.e. STAGES cycles from presentation.
- Stall=1, flush=0:
  - all stages hold;
  - in_valid is ignored and the entry is dropped (upstream holds it);
  - sel_err does not assert.
- Flush=1: has priority over stall. At the next edge every stage gets valid=0 and we=0; addr is don't-care, but the RTL holds it. The entry presented that cycle is discarded.
- Hazard (combinational from stage registers only, no input bypass): hazard_a = OR over i of (stage[i].we & stage[i].addr == src_a) & (src_a != 0). hazard_b is the same for src_b.
- Reset mid-operation: immediate clear, independent of clk.
- No arithmetic. Address width is preserved; no wrap-around applies.

Optional Feature:
- Macro: REG_DST_PIPE_HAZ_IDX_EN.
- Defined:
  - adds outputs haz_idx_a and haz_idx_b, each clog2(STAGES) bits;
  - each gives the index of the youngest (lowest i) matching stage, used for forwarding-mux control;
  - the value is 0 when no hazard.
- Undefined: these ports do not exist and there is no extra logic; everything else is identical.

Decomposition:
- Shared package reg_dst_pkg holds:
  - constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_ILL=2'b11;
  - ZERO_REG=0.
- Sub-module reg_dst_stage: one pipeline register (valid, we, addr) with async reset, hold on stall, clear on flush. It is instantiated STAGES times in a generate loop.
- Select, hazard compare and index priority logic stay in the top module.

Test Plan:
- Reset: rst_n=0 mid-run with all stages valid -> all outputs 0 at once, before the next clk edge.
- Select + latency (STAGES=3): a=0011, b=0101, c=1111, reg_write=1, sel=00/01/10 in consecutive cycles -> out sequence 0011, 0101, 1111 with out_valid=out_we=1, first appearing 3 cycles after presentation.
- Illegal/zero:
  - sel=11 -> sel_err high for 1 cycle, bubble reaches out with out_valid=0;
  - sel=00 with a=0000 -> out_valid=1, out_we=0.
- Stall/flush:
  - stall=1 for 2 cycles with 3 valid entries -> out unchanged, in_valid entries dropped;
  - flush=1 with stall=1 -> all valid cleared next edge, out_valid=0 for 3 cycles.
- Hazard:
  - in-flight write to 0101 -> src_a=0101 gives hazard_a=1, src_b=0110 gives hazard_b=0;
  - src_a=0000 -> hazard_a=0 even if an addr=0 entry is valid;
  - with REG_DST_PIPE_HAZ_IDX_EN, writes to 0101 in stages 0 and 2 -> haz_idx_a=0.
